// File: rtl/game_flow_ctrl.sv
// Game sequencer: owns the IDLE/PLAY/PAUSE/OVER flow, the floor-scroll divider,
// the life counter, the BCD floor score and one-shot buzzer requests.
module game_flow_ctrl #(
  parameter int DIV_BASE  = 1_000_000,
  parameter int DIV_W     = 20,
  parameter int MAX_LIVES = 10,
  parameter int SPIKE_DMG = 3
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        restart,
  input  logic        pause,
  input  logic [1:0]  sw,
  input  logic        land_hit,
  input  logic        spike_hit,
  input  logic        fall_out,
  output logic [1:0]  game_state,
  output logic        run,
  output logic        scroll_tick,
  output logic [3:0]  lives,
  output logic [11:0] score_bcd,
  output logic [1:0]  sfx_req
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [3:0] LIVES_MAX = 4'(MAX_LIVES);
  localparam logic [3:0] DMG       = 4'(SPIKE_DMG);

  state_t           state_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [3:0]       lives_reg;
  logic [11:0]      score_reg;
  logic             tick_reg;
  logic             run_reg;
  logic [1:0]       sfx_reg;

  logic [DIV_W-1:0] period_m1;
  logic             tick_due;
  logic [3:0]       lives_heal;
  logic [3:0]       lives_dmg;
  logic             leave_play;
  logic [3:0]       carry;
  logic [11:0]      score_inc;
  logic [11:0]      score_sat;

  // The >= compare lets a speed increase mid-count fire on the next PLAY cycle.
  assign period_m1 = DIV_W'((DIV_BASE >> sw) - 1);
  assign tick_due  = (cnt_reg >= period_m1);

  assign lives_heal = (lives_reg >= LIVES_MAX) ? LIVES_MAX : lives_reg + 4'd1;
  assign lives_dmg  = (lives_reg > DMG) ? lives_reg - DMG : 4'd0;

  // BCD ripple increment; a carry out of the top digit means the score is 999.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit = score_reg[gi*4 +: 4];
      assign score_inc[gi*4 +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);
    end
  endgenerate
  assign score_sat = carry[3] ? score_reg : score_inc;

  assign leave_play = fall_out
                    | (spike_hit & (lives_dmg == 4'd0))
                    | (!land_hit & !spike_hit & pause);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      lives_reg <= LIVES_MAX;
      score_reg <= '0;
      tick_reg  <= 1'b0;
      run_reg   <= 1'b0;
      sfx_reg   <= 2'b00;
    end else begin
      tick_reg <= 1'b0;
      sfx_reg  <= 2'b00;
      if (restart) begin
        state_reg <= PLAY;
        cnt_reg   <= '0;
        lives_reg <= LIVES_MAX;
        score_reg <= '0;
        run_reg   <= 1'b1;
      end else begin
        case (state_reg)
          PLAY: begin
            if (!leave_play) begin
              if (tick_due) begin
                tick_reg <= 1'b1;
                cnt_reg  <= '0;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            if (fall_out) begin
              state_reg <= OVER;
              run_reg   <= 1'b0;
              sfx_reg   <= 2'b11;
            end else if (spike_hit) begin
              if (land_hit) score_reg <= score_sat;
              lives_reg <= lives_dmg;
              if (lives_dmg == 4'd0) begin
                state_reg <= OVER;
                run_reg   <= 1'b0;
                sfx_reg   <= 2'b11;
              end else begin
                sfx_reg <= 2'b10;
              end
            end else if (land_hit) begin
              score_reg <= score_sat;
              lives_reg <= lives_heal;
              sfx_reg   <= 2'b01;
            end else if (pause) begin
              state_reg <= PAUSE;
              run_reg   <= 1'b0;
            end
          end
          PAUSE: begin
            if (!pause) begin
              state_reg <= PLAY;
              run_reg   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign game_state  = state_reg;
  assign run         = run_reg;
  assign scroll_tick = tick_reg;
  assign lives       = lives_reg;
  assign score_bcd   = score_reg;
  assign sfx_req     = sfx_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a behavioural model pushes expected outputs
// per cycle, popped and compared after each clock edge, plus directed spot checks.
module tb_game_flow_ctrl;

  logic        clk_50m = 1'b0;
  logic        rst = 1'b0, restart = 1'b0, pause = 1'b0;
  logic        land_hit = 1'b0, spike_hit = 1'b0, fall_out = 1'b0;
  logic [1:0]  sw = 2'd0;
  logic [1:0]  game_state;
  logic        run, scroll_tick;
  logic [3:0]  lives;
  logic [11:0] score_bcd;
  logic [1:0]  sfx_req;

  game_flow_ctrl #(.DIV_BASE(16), .DIV_W(5), .MAX_LIVES(10), .SPIKE_DMG(3)) dut (
    .clk_50m(clk_50m), .rst(rst), .restart(restart), .pause(pause), .sw(sw),
    .land_hit(land_hit), .spike_hit(spike_hit), .fall_out(fall_out),
    .game_state(game_state), .run(run), .scroll_tick(scroll_tick),
    .lives(lives), .score_bcd(score_bcd), .sfx_req(sfx_req)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct packed {
    logic [1:0]  st;
    logic        run;
    logic        tick;
    logic [3:0]  lives;
    logic [11:0] score;
    logic [1:0]  sfx;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_state = 0, m_cnt = 0, m_lives = 10, m_score = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // One clock of stimulus: drive, model, push expectation, then pop and compare.
  task automatic step(input logic r, input logic rs, input logic la, input logic sp, input logic fa);
    exp_t e;
    int   period;
    logic leave;
    @(negedge clk_50m);
    rst = r; restart = rs; land_hit = la; spike_hit = sp; fall_out = fa;
    e.tick = 1'b0;
    e.sfx  = 2'b00;
    if (r) begin
      m_state = 0; m_cnt = 0; m_lives = 10; m_score = 0;
    end else if (rs) begin
      m_state = 1; m_cnt = 0; m_lives = 10; m_score = 0;
    end else if (m_state == 1) begin
      leave = 1'b0;
      if (fa) begin
        m_state = 3; e.sfx = 2'b11; leave = 1'b1;
      end else if (sp) begin
        if (la && m_score < 999) m_score++;
        m_lives = (m_lives > 3) ? m_lives - 3 : 0;
        if (m_lives == 0) begin
          m_state = 3; e.sfx = 2'b11; leave = 1'b1;
        end else begin
          e.sfx = 2'b10;
        end
      end else if (la) begin
        if (m_score < 999) m_score++;
        if (m_lives < 10) m_lives++;
        e.sfx = 2'b01;
      end else if (pause) begin
        m_state = 2; leave = 1'b1;
      end
      if (!leave) begin
        period = 16 >> sw;
        if (m_cnt >= period - 1) begin
          e.tick = 1'b1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end else if (m_state == 2 && !pause) begin
      m_state = 1;
    end
    e.st    = 2'(m_state);
    e.run   = (m_state == 1);
    e.lives = 4'(m_lives);
    e.score = to_bcd(m_score);
    exp_q.push_back(e);
    @(posedge clk_50m);
    #1;
    e = exp_q.pop_front();
    check("state", {30'd0, game_state}, {30'd0, e.st});
    check("run", {31'd0, run}, {31'd0, e.run});
    check("tick", {31'd0, scroll_tick}, {31'd0, e.tick});
    check("lives", {28'd0, lives}, {28'd0, e.lives});
    check("score", {20'd0, score_bcd}, {20'd0, e.score});
    check("sfx", {30'd0, sfx_req}, {30'd0, e.sfx});
    land_hit = 1'b0; spike_hit = 1'b0; fall_out = 1'b0; restart = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Cycles until the next scroll tick, bounded so a dead divider cannot hang the run.
  task automatic until_tick(input int bound, output int n);
    n = 0;
    do begin
      idle_step();
      n++;
    end while (!scroll_tick && n < bound);
  endtask

  initial begin
    int n;
    int ticks;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_state", {30'd0, game_state}, 32'd0);
    check("rst_lives", {28'd0, lives}, 32'd10);
    check("rst_score", {20'd0, score_bcd}, 32'h000);
    check("rst_run", {31'd0, run}, 32'd0);

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_land_dropped", {20'd0, score_bcd}, 32'h000);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_state", {30'd0, game_state}, 32'd1);
    check("restart_run", {31'd0, run}, 32'd1);

    until_tick(40, n);
    check("tick_gap_sw0_a", n, 16);
    until_tick(40, n);
    check("tick_gap_sw0_b", n, 16);
    sw = 2'd3;
    until_tick(40, n);
    check("tick_gap_sw3_a", n, 2);
    until_tick(40, n);
    check("tick_gap_sw3_b", n, 2);

    sw = 2'd0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) idle_step();
    sw = 2'd2;
    idle_step();
    check("sw_drop_tick", {31'd0, scroll_tick}, 32'd1);

    sw = 2'd0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) idle_step();
    pause = 1'b1;
    ticks = 0;
    repeat (40) begin
      idle_step();
      ticks += int'(scroll_tick);
    end
    check("pause_no_ticks", ticks, 0);
    check("pause_state", {30'd0, game_state}, 32'd2);
    pause = 1'b0;
    idle_step();
    check("resume_state", {30'd0, game_state}, 32'd1);
    until_tick(30, n);
    check("resume_first_tick", n, 11);

    pause = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_over_pause", {30'd0, game_state}, 32'd1);
    idle_step();
    check("pause_after_restart", {30'd0, game_state}, 32'd2);
    pause = 1'b0;

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (99) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("score_099", {20'd0, score_bcd}, 32'h099);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("score_100", {20'd0, score_bcd}, 32'h100);
    check("score_100_sfx", {30'd0, sfx_req}, 32'd1);
    check("score_100_lives", {28'd0, lives}, 32'd10);
    repeat (899) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("score_999", {20'd0, score_bcd}, 32'h999);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("score_sat", {20'd0, score_bcd}, 32'h999);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lives_4", {28'd0, lives}, 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("spike_lives_1", {28'd0, lives}, 32'd1);
    check("spike_sfx", {30'd0, sfx_req}, 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("spike_lives_0", {28'd0, lives}, 32'd0);
    check("spike_over", {30'd0, game_state}, 32'd3);
    check("spike_over_sfx", {30'd0, sfx_req}, 32'd3);
    idle_step();
    check("sfx_one_shot", {30'd0, sfx_req}, 32'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("combo_lives", {28'd0, lives}, 32'd7);
    check("combo_score", {20'd0, score_bcd}, 32'h006);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("fall_state", {30'd0, game_state}, 32'd3);
    check("fall_sfx", {30'd0, sfx_req}, 32'd3);
    check("fall_lives", {28'd0, lives}, 32'd7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("over_land_dropped", {20'd0, score_bcd}, 32'h006);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("replay_state", {30'd0, game_state}, 32'd1);
    check("replay_lives", {28'd0, lives}, 32'd10);
    check("replay_score", {20'd0, score_bcd}, 32'h000);
    until_tick(40, n);
    check("replay_cnt_cleared", n, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
